// File: rtl/sha256_ring_pkg.sv
// Shared ring flit layout for the SHA-256 node assembler/deassembler.
// Field offsets, flit types, body count and the transfer FSM states.
package sha256_ring_pkg;

  localparam int PAYLOAD_LSB = 0;
  localparam int PAYLOAD_W   = 64;
  localparam int ID_LSB      = 64;
  localparam int ID_W        = 4;
  localparam int TYPE_LSB    = 68;
  localparam int TYPE_W      = 4;
  localparam int FLIT_MIN_W  = 72;

  localparam logic [TYPE_W-1:0] HDR_TYPE  = 4'h1;
  localparam logic [TYPE_W-1:0] BODY_TYPE = 4'h2;

  localparam int NONCE_W  = 32;
  localparam int DIGEST_W = 256;

  localparam int HDR_FOUND_BIT = 32;
  localparam int HDR_CNT_LSB   = 33;
  localparam int HDR_CNT_W     = 3;

  localparam int BODY_FLITS = 4;
  localparam int BODY_CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } ring_state_e;

  function automatic logic [PAYLOAD_W-1:0] hdr_payload(
    input logic                 found,
    input logic [NONCE_W-1:0]   nonce,
    input logic [HDR_CNT_W-1:0] cnt
  );
    logic [PAYLOAD_W-1:0] p;
    p = '0;
    p[NONCE_W-1:0] = nonce;
    p[HDR_FOUND_BIT] = found;
    p[HDR_CNT_LSB +: HDR_CNT_W] = cnt;
    return p;
  endfunction

endpackage

// File: rtl/sha256_result_deassembler.sv
// Serializes one mining result into ring flits (header + digest bodies).
// SHA256_DEASM_DIGEST_EN adds the four digest body flits per packet.
module sha256_result_deassembler
  import sha256_ring_pkg::*;
#(
  parameter int ring_width_p = 80,
  parameter int id_p         = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    en_i,
  input  logic                    v_i,
  input  logic                    found_i,
  input  logic [NONCE_W-1:0]      nonce_i,
  input  logic [DIGEST_W-1:0]     digest_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [ring_width_p-1:0] data_o,
  input  logic                    yumi_i
);

  localparam logic [ID_W-1:0] id_lp = ID_W'(id_p);

`ifdef SHA256_DEASM_DIGEST_EN
  localparam logic [HDR_CNT_W-1:0] hdr_cnt_lp = HDR_CNT_W'(BODY_FLITS);
`else
  localparam logic [HDR_CNT_W-1:0] hdr_cnt_lp = '0;
`endif

  if (ring_width_p < FLIT_MIN_W) begin : g_width_chk
    $error("ring_width_p must be >= 72");
  end

  ring_state_e          state_q;
  logic                 found_q;
  logic [NONCE_W-1:0]   nonce_q;
  logic                 accept;
  logic                 take;

`ifdef SHA256_DEASM_DIGEST_EN
  logic [DIGEST_W-1:0]   digest_q;
  logic [BODY_CNT_W-1:0] cnt_q;
  logic [PAYLOAD_W-1:0]  body_word;
`else
  logic unused_digest;
  assign unused_digest = ^digest_i;
`endif

  // Outputs depend on registered state and en_i only, never on yumi_i.
  assign ready_o = reset_n_i & en_i & (state_q == IDLE);
  assign v_o     = en_i & (state_q != IDLE);
  assign accept  = v_i & ready_o;
  assign take    = v_o & yumi_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      found_q  <= 1'b0;
      nonce_q  <= '0;
`ifdef SHA256_DEASM_DIGEST_EN
      digest_q <= '0;
      cnt_q    <= '0;
`endif
    end else if (en_i) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            found_q  <= found_i;
            nonce_q  <= nonce_i;
`ifdef SHA256_DEASM_DIGEST_EN
            digest_q <= digest_i;
`endif
            state_q  <= HDR;
          end
        end
        HDR: begin
          if (take) begin
`ifdef SHA256_DEASM_DIGEST_EN
            cnt_q   <= '0;
            state_q <= BODY;
`else
            state_q <= IDLE;
`endif
          end
        end
`ifdef SHA256_DEASM_DIGEST_EN
        BODY: begin
          if (take) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == BODY_CNT_W'(BODY_FLITS - 1))
              state_q <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SHA256_DEASM_DIGEST_EN
  // Most-significant digest word goes out first.
  always_comb begin
    body_word = '0;
    unique case (cnt_q)
      2'd0: body_word = digest_q[255:192];
      2'd1: body_word = digest_q[191:128];
      2'd2: body_word = digest_q[127:64];
      2'd3: body_word = digest_q[63:0];
      default: body_word = '0;
    endcase
  end
`endif

  always_comb begin
    data_o = '0;
    unique case (1'b1)
      (state_q == HDR): begin
        data_o[PAYLOAD_LSB +: PAYLOAD_W] =
          hdr_payload(found_q, nonce_q, hdr_cnt_lp);
        data_o[ID_LSB +: ID_W]     = id_lp;
        data_o[TYPE_LSB +: TYPE_W] = HDR_TYPE;
      end
`ifdef SHA256_DEASM_DIGEST_EN
      (state_q == BODY): begin
        data_o[PAYLOAD_LSB +: PAYLOAD_W] = body_word;
        data_o[ID_LSB +: ID_W]     = id_lp;
        data_o[TYPE_LSB +: TYPE_W] = BODY_TYPE;
      end
`endif
      default: ;
    endcase
  end

  yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o
  );

endmodule

// File: tb/tb_sha256_result_deassembler.sv
// Scoreboard bench for sha256_result_deassembler.
// Works with or without SHA256_DEASM_DIGEST_EN.
`timescale 1ns/1ps
module tb_sha256_result_deassembler;

  localparam int W  = 80;
  localparam int ID = 5;
`ifdef SHA256_DEASM_DIGEST_EN
  localparam int NBODY = 4;
`else
  localparam int NBODY = 0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         en = 1'b0;
  logic         v_i = 1'b0;
  logic         found = 1'b0;
  logic [31:0]  nonce = '0;
  logic [255:0] digest = '0;
  logic         yumi = 1'b0;
  logic         ready;
  logic         v_o;
  logic [W-1:0] data;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int taken = 0;
  int yumi_mode = 0;
  int yumi_ctr = 0;
  bit held_valid = 0;
  logic [W-1:0] held_data = '0;

  always #5 clk = ~clk;

  sha256_result_deassembler #(
    .ring_width_p(W),
    .id_p(ID)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .en_i(en),
    .v_i(v_i),
    .found_i(found),
    .nonce_i(nonce),
    .digest_i(digest),
    .ready_o(ready),
    .v_o(v_o),
    .data_o(data),
    .yumi_i(yumi)
  );

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", nm);
  endtask

  function automatic logic [W-1:0] mk_flit(int typ, logic [63:0] pl);
    return W'(pl) | (W'(ID) << 64) | (W'(typ) << 68);
  endfunction

  // Reference packet: header, then digest words high to low.
  task automatic model_packet(logic f, logic [31:0] n, logic [255:0] d);
    logic [63:0] pl;
    pl = 64'(n) + (64'(f) << 32) + (64'(NBODY) << 33);
    exp_q.push_back(mk_flit(1, pl));
    for (int k = 0; k < NBODY; k++)
      exp_q.push_back(mk_flit(2, 64'(d >> (64 * (3 - k)))));
  endtask

  // Inputs change at negedge+1, ready sampled at +2.
  task automatic send(input logic f, input logic [31:0] n,
                      input logic [255:0] d, input bit rnd_en,
                      output int waits);
    int budget;
    budget = 300;
    waits = 0;
    @(negedge clk);
    #1;
    while (1) begin
      if (rnd_en) en = ($urandom_range(0, 9) != 0);
      v_i = 1'b1;
      found = f;
      nonce = n;
      digest = d;
      #1;
      if (ready) begin
        model_packet(f, n, d);
        @(posedge clk);
        #1;
        v_i = 1'b0;
        digest = {8{$urandom()}};
        nonce = $urandom();
        return;
      end
      waits++;
      budget--;
      if (budget == 0) begin
        fail_now("send_timeout");
        v_i = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 400;
    @(negedge clk);
    #1;
    en = 1'b1;
    #3;
    while ((exp_q.size() != 0 || v_o) && budget > 0) begin
      @(negedge clk);
      #4;
      budget--;
    end
    if (budget == 0) fail_now("drain_timeout");
    chk("idle_ready", W'(ready), W'(1));
  endtask

  task automatic wait_taken(int target);
    int budget;
    budget = 300;
    while (taken < target && budget > 0) begin
      @(negedge clk);
      #4;
      budget--;
    end
    if (budget == 0) fail_now("wait_taken_timeout");
  endtask

  // Consumer: yumi only ever asserted alongside v_o.
  initial begin
    forever begin
      logic want;
      @(negedge clk);
      #2;
      case (yumi_mode)
        0: want = 1'b1;
        1: begin
          want = (yumi_ctr % 3 == 2);
          yumi_ctr++;
        end
        default: want = ($urandom_range(0, 2) != 0);
      endcase
      yumi = want & v_o;
    end
  end

  // Monitor: pops the scoreboard on every accepted flit.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!reset_n) begin
        held_valid = 0;
      end else begin
        if (!en) begin
          chk("stall_v_o", W'(v_o), W'(0));
          chk("stall_ready", W'(ready), W'(0));
        end
        if (v_o) begin
          if (held_valid) chk("hold_stable", data, held_data);
          if (yumi) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_flit: got %h expected none", data);
            end else begin
              chk("flit", data, exp_q.pop_front());
            end
            taken++;
            held_valid = 0;
          end else begin
            held_valid = 1;
            held_data = data;
          end
        end else if (en && held_valid) begin
          chk("flit_dropped", W'(v_o), W'(1));
          held_valid = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int base;
    logic [255:0] dg;
    dg = 256'h00112233445566778899AABBCCDDEEFF_00112233445566778899AABBCCDDEEFF;
    en = 1'b1;
    #12;
    chk("rst_v_o", W'(v_o), W'(0));
    chk("rst_ready", W'(ready), W'(0));
    chk("rst_data", data, '0);
    @(negedge clk);
    #4;
    reset_n = 1'b1;
    @(negedge clk);
    #2;
    chk("ready_after_rst", W'(ready), W'(1));

    // Basic packet with fixed header expectation.
    yumi_mode = 0;
    send(1'b1, 32'hDEADBEEF, dg, 0, w);
    @(negedge clk);
    #2;
    chk("hdr_latency_v", W'(v_o), W'(1));
    chk("hdr_payload", W'(data[63:0]),
        W'(NBODY != 0 ? 64'h0000_0009_DEADBEEF : 64'h0000_0001_DEADBEEF));
    chk("hdr_type_id", W'(data[71:64]), W'(8'h15));
    drain();

    // Back-pressure: yumi every third cycle.
    yumi_mode = 1;
    send(1'b1, 32'hDEADBEEF, dg, 0, w);
    drain();

    // Busy rejection: next result waits for the IDLE cycle.
    yumi_mode = 0;
    send(1'b1, 32'hCAFEF00D, dg, 0, w);
    send(1'b0, 32'h1, ~dg, 0, w);
    chk("busy_wait_cycles", W'(w), W'(NBODY + 1));
    drain();

    // Enable stall after body 1 is taken.
    base = taken;
    send(1'b1, 32'h0BAD_F00D, {8{$urandom()}}, 0, w);
    wait_taken(base + (NBODY != 0 ? 3 : 0));
    @(negedge clk);
    #1;
    en = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    en = 1'b1;
    drain();
    chk("stall_flits", W'(taken - base), W'(NBODY + 1));

    // Asynchronous reset in the middle of a packet.
    yumi_mode = 1;
    base = taken;
    send(1'b1, 32'h5555_AAAA, {8{$urandom()}}, 0, w);
    if (NBODY != 0) wait_taken(base + 3);
    else begin
      @(negedge clk);
      #4;
    end
    @(negedge clk);
    #5;
    reset_n = 1'b0;
    #1;
    chk("async_rst_v_o", W'(v_o), W'(0));
    chk("async_rst_data", data, '0);
    exp_q.delete();
    held_valid = 0;
    repeat (2) @(negedge clk);
    #4;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2;
      chk("post_rst_ready", W'(ready), W'(1));
      chk("post_rst_no_flit", W'(v_o), W'(0));
    end

    // Found=0 result is still sent.
    yumi_mode = 0;
    send(1'b0, 32'h12345678, {8{$urandom()}}, 0, w);
    @(negedge clk);
    #2;
    chk("nf_hdr_payload", W'(data[63:0]),
        W'(NBODY != 0 ? 64'h0000_0008_12345678 : 64'h0000_0000_12345678));
    drain();

    // Random results, random back-pressure and enable.
    yumi_mode = 2;
    for (int p = 0; p < 25; p++)
      send(1'($urandom_range(0, 1)), $urandom(), {8{$urandom()}}, 1, w);
    drain();
    chk("queue_empty", W'(exp_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
